// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM encoding,
// word geometry and a constant-evaluable ceiling log2.
package uart_tx_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_INIT     = 3'd0,
      ST_IDLE     = 3'd1,
      ST_SEND     = 3'd2,
      ST_WAIT_END = 3'd3,
      ST_CLEAR    = 3'd4,
      ST_DONE     = 3'd5
   } state_e;

   localparam int BYTES_PER_WORD = 4;

   function automatic int ceil_log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: search starts one past rr_ptr and wraps,
// so the requester served last has the lowest priority.
module rr_arbiter_n #(
   parameter int NREQ = 2
) (
   input  logic            en,
   input  logic [NREQ-1:0] req,
   input  logic [2:0]      rr_ptr,
   output logic [NREQ-1:0] win_oh,
   output logic [2:0]      win_idx
);

   int   cand;
   logic found;

   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      cand    = 0;
      found   = 1'b0;
      if (en) begin
         for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (!found && req[cand]) begin
               found        = 1'b1;
               win_oh[cand] = 1'b1;
               win_idx      = 3'(cand);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ requesters; the granted 32-bit word
// goes out LSB byte first, with a per-byte watchdog and a sticky timeout flag.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int CLK_FREQ    = 50000000,
   parameter int BAUDRATE    = 9600,
   parameter int TIMEOUT_CYC = 12 * (CLK_FREQ / BAUDRATE)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   req_data,
   input  logic [2*NREQ-1:0]    req_len,
   output logic [NREQ-1:0]      ack,
   output logic                 busy,
   output logic [2:0]           grant_id,
   output logic                 timeout_err,
   output logic                 uart_transmit,
   output logic [7:0]           uart_data,
   output logic                 uart_clr_tx_n,
   input  logic                 uart_end_tx
);

   localparam int WORD_W = 8 * BYTES_PER_WORD;
   localparam int IDX_W  = $clog2(BYTES_PER_WORD);
   localparam int WDOG_W = ceil_log2(TIMEOUT_CYC) + 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [IDX_W-1:0]    len_q, len_d;
   logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
   logic [IDX_W-1:0]    nxt_idx;
   logic [WDOG_W-1:0]   wdog_q, wdog_d;
   logic                abort_q, abort_d;
   logic [2:0]          grant_q, grant_d;
   logic [2:0]          rr_q, rr_d;
   logic                terr_q, terr_d;
   logic                xmit_q, xmit_d;
   logic [7:0]          data_q, data_d;
   logic                clr_n_q, clr_n_d;

   logic                arb_en;
   logic [NREQ-1:0]     win_oh;
   logic [2:0]          win_idx;
   logic [WORD_W-1:0]   sel_word;
   logic [IDX_W-1:0]    sel_len;

   rr_arbiter_n #(.NREQ(NREQ)) u_arb (
      .en      (arb_en),
      .req     (req),
      .rr_ptr  (rr_q),
      .win_oh  (win_oh),
      .win_idx (win_idx)
   );

   always_comb begin
      sel_word = '0;
      sel_len  = '0;
      for (int i = 0; i < NREQ; i++) begin
         sel_word |= {WORD_W{win_oh[i]}} & req_data[32*i +: 32];
         sel_len  |= {IDX_W{win_oh[i]}} & req_len[2*i +: 2];
      end
   end

   assign nxt_idx = byte_idx_q + IDX_W'(1);

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      len_d      = len_q;
      byte_idx_d = byte_idx_q;
      wdog_d     = wdog_q;
      abort_d    = abort_q;
      grant_d    = grant_q;
      rr_d       = rr_q;
      terr_d     = terr_q;
      data_d     = data_q;
      arb_en     = 1'b0;
      unique case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: begin
            arb_en = 1'b1;
            if (|req) begin
               word_d     = sel_word;
               len_d      = sel_len;
               grant_d    = win_idx;
               byte_idx_d = '0;
               data_d     = sel_word[7:0];
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            wdog_d  = '0;
            state_d = ST_WAIT_END;
         end
         ST_WAIT_END: begin
            if (uart_end_tx) begin
               state_d = ST_CLEAR;
            end else if (wdog_q == WDOG_LAST) begin
               terr_d  = 1'b1;
               abort_d = 1'b1;
               state_d = ST_CLEAR;
            end else if (wdog_q != '1) begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end
         ST_CLEAR: begin
            if (abort_q || byte_idx_q == len_q) begin
               state_d = ST_DONE;
            end else begin
               byte_idx_d = nxt_idx;
               data_d     = word_q[{nxt_idx, 3'b000} +: 8];
               state_d    = ST_SEND;
            end
         end
         ST_DONE: begin
            rr_d    = grant_q;
            abort_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_INIT;
      endcase
      // Strobe registered off the next state so it is high exactly while in SEND;
      // the flag clear lands the cycle after INIT/CLEAR, keeping reset value high.
      xmit_d  = (state_d == ST_SEND);
      clr_n_d = !(state_q == ST_INIT || state_q == ST_CLEAR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_INIT;
         word_q     <= '0;
         len_q      <= '0;
         byte_idx_q <= '0;
         wdog_q     <= '0;
         abort_q    <= 1'b0;
         grant_q    <= '0;
         rr_q       <= 3'(NREQ - 1);
         terr_q     <= 1'b0;
         xmit_q     <= 1'b0;
         data_q     <= '0;
         clr_n_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         len_q      <= len_d;
         byte_idx_q <= byte_idx_d;
         wdog_q     <= wdog_d;
         abort_q    <= abort_d;
         grant_q    <= grant_d;
         rr_q       <= rr_d;
         terr_q     <= terr_d;
         xmit_q     <= xmit_d;
         data_q     <= data_d;
         clr_n_q    <= clr_n_d;
      end
   end

   always_comb begin
      ack = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (state_q == ST_DONE && grant_q == 3'(i)) ack[i] = 1'b1;
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign grant_id      = grant_q;
   assign timeout_err   = terr_q;
   assign uart_transmit = xmit_q;
   assign uart_data     = data_q;
   assign uart_clr_tx_n = clr_n_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: behavioural UART transmitter (16 clk/bit) plus serial-line
// monitor around uart_tx_arbiter, checked with immediate assertions.
module tb_uart_tx_arbiter;

   localparam int NREQ    = 2;
   localparam int BIT_CYC = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req = '0;
   logic [63:0] req_data = '0;
   logic [3:0]  req_len = '0;
   logic [1:0]  ack;
   logic        busy;
   logic [2:0]  grant_id;
   logic        timeout_err;
   logic        uart_transmit;
   logic [7:0]  uart_data;
   logic        uart_clr_tx_n;
   logic        uart_end_tx;

   logic        end_flag = 1'b0;
   logic        force_end_low = 1'b0;
   assign uart_end_tx = end_flag & ~force_end_low;

   uart_tx_arbiter #(
      .NREQ(NREQ), .CLK_FREQ(16), .BAUDRATE(1), .TIMEOUT_CYC(200)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_len(req_len),
      .ack(ack), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err),
      .uart_transmit(uart_transmit), .uart_data(uart_data),
      .uart_clr_tx_n(uart_clr_tx_n), .uart_end_tx(uart_end_tx)
   );

   initial forever #5 clk = ~clk;

   // UART transmitter model: own reset (none), 8N1, end flag held until cleared.
   logic [9:0] shreg = '1;
   logic       tx_busy = 1'b0;
   int         bit_cnt = 0, cyc_cnt = 0;
   int         tx_pulses = 0, ack_cnt = 0, overruns = 0;
   logic       line;
   assign line = tx_busy ? shreg[0] : 1'b1;

   always @(posedge clk) begin
      if (uart_transmit) tx_pulses <= tx_pulses + 1;
      if (ack != 2'b00) ack_cnt <= ack_cnt + 1;
      if (uart_transmit && tx_busy) overruns <= overruns + 1;
      if (!uart_clr_tx_n) end_flag <= 1'b0;
      if (uart_transmit && !tx_busy) begin
         shreg   <= {1'b1, uart_data, 1'b0};
         tx_busy <= 1'b1;
         bit_cnt <= 0;
         cyc_cnt <= 0;
      end else if (tx_busy) begin
         if (cyc_cnt == BIT_CYC - 1) begin
            cyc_cnt <= 0;
            shreg   <= {1'b1, shreg[9:1]};
            bit_cnt <= bit_cnt + 1;
            if (bit_cnt == 9) begin
               tx_busy  <= 1'b0;
               end_flag <= 1'b1;
            end
         end else begin
            cyc_cnt <= cyc_cnt + 1;
         end
      end
   end

   // Serial monitor: frames stored as {stop_bit, data_byte}.
   logic [8:0] rx_q[$];
   initial begin
      logic [8:0] fr;
      forever begin
         @(negedge clk);
         if (line == 1'b0) begin
            repeat (BIT_CYC / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BIT_CYC) @(negedge clk);
               fr[i] = line;
            end
            repeat (BIT_CYC) @(negedge clk);
            fr[8] = line;
            rx_q.push_back(fr);
         end
      end
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input string tag);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge clk);
         if (ack != 2'b00) seen = 1'b1;
      end
      chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic check_bytes(input string tag, input int base, input logic [31:0] d, input int nb);
      chk({tag, "_nbytes"}, 32'(rx_q.size() - base), 32'(nb));
      for (int b = 0; b < nb; b++) begin
         if (base + b < rx_q.size()) begin
            chk({tag, "_byte"}, 32'(rx_q[base+b][7:0]), 32'(d[8*b +: 8]));
            chk({tag, "_stop"}, 32'(rx_q[base+b][8]), 32'd1);
         end
      end
   endtask

   task automatic run_word(input string tag, input int idx, input logic [31:0] d,
                           input logic [1:0] l, input int hold);
      int rx0, tx0, ack0;
      rx0 = rx_q.size();
      tx0 = tx_pulses;
      ack0 = ack_cnt;
      req_data[32*idx +: 32] = d;
      req_len[2*idx +: 2]    = l;
      req[idx]               = 1'b1;
      @(negedge clk);
      chk({tag, "_xmit"}, 32'(uart_transmit), 32'd1);
      chk({tag, "_data0"}, 32'(uart_data), 32'(d[7:0]));
      chk({tag, "_gid"}, 32'(grant_id), 32'(idx));
      repeat (hold) @(negedge clk);
      req[idx] = 1'b0;
      wait_ack(tag);
      chk({tag, "_ack"}, 32'(ack), 32'(1 << idx));
      @(negedge clk);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_ack_low"}, 32'(ack), 32'd0);
      chk({tag, "_ack_cnt"}, 32'(ack_cnt - ack0), 32'd1);
      chk({tag, "_tx_cnt"}, 32'(tx_pulses - tx0), 32'(l) + 32'd1);
      check_bytes(tag, rx0, d, int'(l) + 1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int rx0, tx0, ack0;
      bit reached;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      chk("rst_xmit", 32'(uart_transmit), 32'd0);
      chk("rst_data", 32'(uart_data), 32'd0);
      chk("rst_clr", 32'(uart_clr_tx_n), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("init_clr_low", 32'(uart_clr_tx_n), 32'd0);
      chk("init_idle", 32'(busy), 32'd0);
      @(negedge clk);
      chk("init_clr_high", 32'(uart_clr_tx_n), 32'd1);

      // Contention: grant order 0,1,0,1 from reset
      rx0 = rx_q.size();
      req_data = {32'h0000_0022, 32'h0000_0011};
      req_len  = 4'b0000;
      req      = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_ack("cont");
         chk("cont_ack", 32'(ack), (k % 2 == 0) ? 32'd1 : 32'd2);
         chk("cont_gid", 32'(grant_id), 32'(k % 2));
         if (k == 3) req = 2'b00;
      end
      @(negedge clk);
      chk("cont_idle", 32'(busy), 32'd0);
      check_bytes("cont", rx0, 32'h2211_2211, 4);

      // Single full word, partial length
      run_word("single", 0, 32'hA5C3_0F81, 2'd3, 0);
      run_word("partial", 1, 32'hDEAD_BEEF, 2'd1, 0);

      // Timeout on first of three bytes
      force_end_low = 1'b1;
      rx0 = rx_q.size();
      tx0 = tx_pulses;
      req_data[63:32] = 32'h00CC_BBAA;
      req_len[3:2]    = 2'd2;
      req[1]          = 1'b1;
      @(negedge clk);
      chk("to_xmit", 32'(uart_transmit), 32'd1);
      req[1] = 1'b0;
      repeat (200) @(negedge clk);
      chk("to_err_before", 32'(timeout_err), 32'd0);
      @(negedge clk);
      chk("to_err_set", 32'(timeout_err), 32'd1);
      @(negedge clk);
      chk("to_ack", 32'(ack), 32'd2);
      force_end_low = 1'b0;
      repeat (250) @(negedge clk);
      chk("to_tx_cnt", 32'(tx_pulses - tx0), 32'd1);
      check_bytes("to", rx0, 32'h0000_00AA, 1);
      chk("to_sticky", 32'(timeout_err), 32'd1);
      chk("to_idle", 32'(busy), 32'd0);

      // Reset during byte 2 of 4
      rx0  = rx_q.size();
      tx0  = tx_pulses;
      ack0 = ack_cnt;
      req_data[31:0] = 32'h4433_2211;
      req_len[1:0]   = 2'd3;
      req[0]         = 1'b1;
      @(negedge clk);
      req[0] = 1'b0;
      reached = 1'b0;
      for (int c = 0; c < 1000 && !reached; c++) begin
         @(negedge clk);
         if (tx_pulses - tx0 == 2) reached = 1'b1;
      end
      chk("mr_byte2_started", 32'(reached), 32'd1);
      repeat (40) @(negedge clk);
      reset = 1'b1;
      repeat (200) @(negedge clk);
      chk("mr_rst_busy", 32'(busy), 32'd1);
      chk("mr_rst_terr", 32'(timeout_err), 32'd0);
      chk("mr_rst_clr", 32'(uart_clr_tx_n), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("mr_clr_low", 32'(uart_clr_tx_n), 32'd0);
      @(negedge clk);
      chk("mr_clr_high", 32'(uart_clr_tx_n), 32'd1);
      chk("mr_flag_cleared", 32'(uart_end_tx), 32'd0);
      chk("mr_no_ack", 32'(ack_cnt - ack0), 32'd0);
      check_bytes("mr", rx0, 32'h0000_2211, 2);
      run_word("after_rst", 1, 32'h0000_0077, 2'd0, 0);

      // Requester drops req one cycle after grant
      run_word("reqdrop", 0, 32'h0403_0201, 2'd3, 1);

      chk("no_overrun", 32'(overruns), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
